// File: rtl/ct_merge_arb.sv
// Packet-level round-robin merge of NI streams into one registered output stream.
// Once a packet wins arbitration, it holds the output until its end-of-packet beat.
module ct_merge_arb #(
  parameter int NI    = 2,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NI*WIDTH-1:0]   i_data,
  input  logic [NI-1:0]         i_valid,
  output logic [NI-1:0]         o_ready,
  input  logic [NI-1:0]         i_eop,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_eop,
  input  logic                  i_ready
);

  localparam int PW = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [NI-1:0]      grant;
  logic [PW-1:0]      ptr;
  logic               ld;
  logic               accept;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_eop;
  logic               vld_p1;
  logic [WIDTH-1:0]   data_p1;
  logic               eop_p1;

  assign ld     = ~vld_p1 | i_ready;
  assign accept = |(i_valid & o_ready);

  // Round-robin search: the first requester after the last winner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NI; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (!win_found && i_valid[i] && (i == (int'(ptr) + k) % NI)) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_eop  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sel_data = sel_data | (i_data[WIDTH*i +: WIDTH] & {WIDTH{grant[i]}});
      sel_eop  = sel_eop | (i_eop[i] & grant[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (win_found) state_nxt = LOCKED;
      LOCKED: if (accept && sel_eop) state_nxt = IDLE;
    endcase
  end

  // Ready comes only from registered state and i_ready, never from i_valid.
  always_comb begin
    o_ready = '0;
    if (state == LOCKED) o_ready = grant & {NI{ld}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= '0;
      ptr   <= PW'(NI - 1);
    end else if (state == IDLE) begin
      if (win_found) begin
        grant <= NI'(1) << win_idx;
        ptr   <= win_idx;
      end
    end else if (accept && sel_eop) begin
      grant <= '0;
    end
  end

  // ---- output register stage (p1) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      eop_p1  <= 1'b0;
    end else if (ld) begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= sel_data;
        eop_p1  <= sel_eop;
      end
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_eop   = eop_p1;

endmodule

// File: tb/tb_ct_merge_arb.sv
// Self-checking bench for ct_merge_arb (NI=3, WIDTH=8): vector table, directed
// sequences and randomized traffic against a packet-level round-robin model.
module tb_ct_merge_arb;
  localparam int NI = 3;
  localparam int W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NI*W-1:0]   i_data;
  logic [NI-1:0]     i_valid, i_eop, o_ready;
  logic              o_valid, o_eop, i_ready;
  logic [W-1:0]      o_data;

  ct_merge_arb #(.NI(NI), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_eop(i_eop), .o_valid(o_valid), .o_data(o_data),
    .o_eop(o_eop), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-stream beat lists and progress pointers (input side / output side).
  logic [7:0] bd [NI][64];
  logic       be [NI][64];
  int         nb [NI];
  int         in_pos [NI];
  int         out_pos [NI];
  bit         hold [NI];
  int         vpct, cyc, cur, last_win;
  bit         ord_chk;
  int         in_order [$];
  logic [7:0] log_d [$];
  logic       log_e [$];
  int         log_c [$];

  typedef struct {
    logic [2:0] mask;
    logic [2:0] exp_ready;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NI; i++) begin
      nb[i] = 0; in_pos[i] = 0; out_pos[i] = 0; hold[i] = 1'b0;
    end
    cur = -1; last_win = NI - 1; ord_chk = 1'b0; vpct = 100;
    in_order.delete(); log_d.delete(); log_e.delete(); log_c.delete();
  endtask

  task automatic add_pkt(input int s, input int len, input logic [7:0] first);
    for (int k = 0; k < len; k++) begin
      bd[s][nb[s]] = first + 8'(k);
      be[s][nb[s]] = (k == len - 1);
      nb[s]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; i_valid = '0; i_eop = '0; i_data = '0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_eop", o_eop, 0);
    chk("rst_o_ready", o_ready, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc = 0;
  endtask

  // Model: the next packet goes to the first stream after the last winner
  // that still has packets to offer.
  function automatic int predict();
    for (int k = 1; k <= NI; k++) begin
      int idx;
      idx = (last_win + k) % NI;
      if (in_pos[idx] < nb[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < NI; i++) if (out_pos[i] != nb[i]) return 1'b0;
    return (cur == -1);
  endfunction

  task automatic step(input logic rdy);
    for (int i = 0; i < NI; i++) begin
      if (in_pos[i] < nb[i] && !hold[i] && ($urandom_range(99) < vpct)) begin
        i_valid[i] = 1'b1;
        i_data[W*i +: W] = bd[i][in_pos[i]];
        i_eop[i] = be[i][in_pos[i]];
      end else begin
        i_valid[i] = 1'b0;
        i_eop[i] = 1'b0;
      end
    end
    i_ready = rdy;
    @(negedge clk);
    chk("ready_onehot", $countones(o_ready) <= 1, 1);
    if (o_valid && i_ready) begin
      log_d.push_back(o_data); log_e.push_back(o_eop); log_c.push_back(cyc);
      if (cur < 0) begin
        chk("sb_start_pending", in_order.size() > 0, 1);
        if (in_order.size() > 0) cur = in_order.pop_front();
      end
      if (cur >= 0) begin
        chk("sb_overrun", out_pos[cur] < nb[cur], 1);
        if (out_pos[cur] < nb[cur]) begin
          logic e;
          e = be[cur][out_pos[cur]];
          chk("sb_data", o_data, bd[cur][out_pos[cur]]);
          chk("sb_eop", o_eop, e);
          out_pos[cur]++;
          if (e) cur = -1;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (i_valid[i] && o_ready[i]) begin
        if (in_pos[i] == 0 || be[i][in_pos[i] - 1]) begin
          if (ord_chk) chk("rr_order", i, predict());
          in_order.push_back(i);
          last_win = i;
        end
        in_pos[i]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_done(input int budget, input int rpct);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin
      step($urandom_range(99) < rpct);
      n++;
    end
    chk("drain_done", all_done(), 1);
    for (int i = 0; i < NI; i++) chk("drain_stream_count", out_pos[i], nb[i]);
  endtask

  task automatic chk_log(input string nm, input logic [7:0] ed[$], input logic ee[$], input int ec[$]);
    chk({nm, "_count"}, log_d.size(), ed.size());
    for (int i = 0; i < ed.size() && i < log_d.size(); i++) begin
      chk({nm, "_data"}, log_d[i], ed[i]);
      chk({nm, "_eop"}, log_e[i], ee[i]);
      chk({nm, "_cycle"}, log_c[i], ec[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ed[$];
    logic       ee[$];
    int         ec[$];

    // ---- arbitration from reset: table of request masks ----
    vecs[0] = '{3'b001, 3'b001, 8'hA0};
    vecs[1] = '{3'b010, 3'b010, 8'hA1};
    vecs[2] = '{3'b100, 3'b100, 8'hA2};
    vecs[3] = '{3'b110, 3'b010, 8'hA1};
    vecs[4] = '{3'b101, 3'b001, 8'hA0};
    vecs[5] = '{3'b111, 3'b001, 8'hA0};
    vecs[6] = '{3'b011, 3'b001, 8'hA0};
    for (int v = 0; v < 7; v++) begin
      clear_all();
      do_reset();
      i_ready = 1'b1;
      for (int s = 0; s < NI; s++) i_data[W*s +: W] = 8'hA0 + 8'(s);
      i_valid = vecs[v].mask;
      i_eop = 3'b111;
      chk("vec_idle_ready", o_ready, 0);
      @(posedge clk); #1;
      chk("vec_ready", o_ready, vecs[v].exp_ready);
      chk("vec_bubble", o_valid, 0);
      @(posedge clk); #1;
      chk("vec_valid", o_valid, 1);
      chk("vec_data", o_data, vecs[v].exp_data);
      chk("vec_eop", o_eop, 1);
      i_valid = '0;
    end

    // ---- single stream, three beats ----
    clear_all(); do_reset();
    add_pkt(1, 3, 8'h11);
    run_until_done(30, 100);
    ed = '{8'h11, 8'h12, 8'h13}; ee = '{0, 0, 1}; ec = '{2, 3, 4};
    chk_log("single", ed, ee, ec);

    // ---- contention, three 2-beat packets ----
    clear_all(); do_reset(); ord_chk = 1'b1;
    add_pkt(0, 2, 8'hA0); add_pkt(1, 2, 8'hB0); add_pkt(2, 2, 8'hC0);
    run_until_done(40, 100);
    ed = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
    ee = '{0, 1, 0, 1, 0, 1}; ec = '{2, 3, 5, 6, 8, 9};
    chk_log("contend", ed, ee, ec);

    // ---- fairness, streams 0 and 2 with single-beat packets ----
    clear_all(); do_reset(); ord_chk = 1'b1;
    for (int p = 0; p < 3; p++) begin
      add_pkt(0, 1, 8'h01 + 8'(p)); add_pkt(2, 1, 8'h21 + 8'(p));
    end
    run_until_done(40, 100);
    ed = '{8'h01, 8'h21, 8'h02, 8'h22, 8'h03, 8'h23};
    ee = '{1, 1, 1, 1, 1, 1}; ec = '{2, 4, 6, 8, 10, 12};
    chk_log("fair", ed, ee, ec);

    // ---- backpressure mid-packet ----
    clear_all(); do_reset();
    add_pkt(0, 4, 8'h31);
    repeat (3) step(1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      chk("bp_valid", o_valid, 1);
      chk("bp_data", o_data, 8'h32);
      chk("bp_ready", o_ready, 0);
    end
    run_until_done(30, 100);
    ed = '{8'h31, 8'h32, 8'h33, 8'h34}; ee = '{0, 0, 0, 1}; ec = '{2, 7, 8, 9};
    chk_log("bp", ed, ee, ec);

    // ---- reset mid-packet ----
    clear_all(); do_reset();
    add_pkt(1, 4, 8'h41);
    repeat (3) step(1'b1);
    chk("rst_pre_valid", o_valid, 1);
    chk("rst_pre_data", o_data, 8'h42);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_eop", o_eop, 0);
    chk("rst_mid_ready", o_ready, 0);
    clear_all(); do_reset(); ord_chk = 1'b1;
    add_pkt(1, 2, 8'h51); add_pkt(0, 1, 8'h61); add_pkt(2, 1, 8'h71);
    run_until_done(30, 100);
    ed = '{8'h61, 8'h51, 8'h52, 8'h71}; ee = '{1, 0, 1, 1}; ec = '{2, 4, 5, 7};
    chk_log("rst_restart", ed, ee, ec);

    // ---- granted stream stalls while others request ----
    clear_all(); do_reset(); ord_chk = 1'b1;
    add_pkt(0, 3, 8'h81); add_pkt(1, 1, 8'h91); add_pkt(2, 1, 8'hA1);
    repeat (2) step(1'b1);
    hold[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("stall_others_ready", o_ready[2:1], 0);
      chk("stall_s1_held", in_pos[1], 0);
      chk("stall_s2_held", in_pos[2], 0);
    end
    chk("stall_s0_pos", in_pos[0], 1);
    hold[0] = 1'b0;
    run_until_done(40, 100);
    ed = '{8'h81, 8'h82, 8'h83, 8'h91, 8'hA1}; ee = '{0, 0, 1, 1, 1};
    ec = '{2, 6, 7, 9, 11};
    chk_log("stall", ed, ee, ec);

    // ---- random traffic with valid gaps: content and packet integrity ----
    clear_all(); do_reset();
    for (int s = 0; s < NI; s++)
      for (int p = 0; p < $urandom_range(2, 4); p++)
        add_pkt(s, $urandom_range(1, 4), 8'($urandom));
    vpct = 70;
    run_until_done(4000, 70);

    // ---- random traffic, streams always offering: round-robin order too ----
    clear_all(); do_reset(); ord_chk = 1'b1;
    for (int s = 0; s < NI; s++)
      for (int p = 0; p < $urandom_range(2, 5); p++)
        add_pkt(s, $urandom_range(1, 4), 8'($urandom));
    run_until_done(4000, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
